// File: rtl/servo_pkg.sv
// Shared definitions for the coin-pusher servo sequencer: FSM states, stroke
// direction encodings and a counter-width helper.
package servo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PUSH_ACK,
      PUSH_WAIT,
      RET_ACK,
      RET_WAIT,
      GAP
   } seq_state_t;

   localparam logic SERVO_BACK  = 1'b1;
   localparam logic SERVO_FRONT = 1'b0;

   // Bits needed to hold (largest count - 1) for a down-counter loaded with N-1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Loadable down-counter: load N-1 on entry, count while enabled, expired once
// the count reaches zero (N enabled cycles after the load).
module seq_dwell_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         timerStart,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] count;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge timerStart) begin
      if (timerStart) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Runs N push/return strokes of the coin-pusher servo per dispense request.
// Optional stroke watchdog enabled by defining SEQ_TIMEOUT_EN.
module coin_dispense_sequencer
   import servo_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int GAP_CYCLES     = 5_000_000,
   parameter int ACK_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 60_000_000
) (
   input  logic             clk,
   input  logic             timerStart,
   input  logic             req_valid,
   input  logic [CNT_W-1:0] req_count,
   output logic             req_ready,
   output logic [31:0]      servo_ctrl,
   input  logic             servo_back_done,
   input  logic             servo_front_done,
   output logic             busy,
   output logic [CNT_W-1:0] coins_left,
   output logic             coin_pulse,
   output logic             done_pulse,
   output logic             error
);

   localparam int TMR_W = cnt_width(GAP_CYCLES, ACK_CYCLES, TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_CYCLES - 1);

   seq_state_t       state, state_nxt;
   logic             servo_bit, servo_nxt;
   logic [CNT_W-1:0] coins_q, coins_nxt;
   logic             coin_pulse_q, coin_pulse_nxt;
   logic             done_q, done_nxt;
   logic             error_q, error_nxt;
   logic             back_d1, front_d1;

   logic             dwell_load, dwell_en, dwell_expired;
   logic [TMR_W-1:0] dwell_val;

   seq_dwell_timer #(.W(TMR_W)) u_dwell_timer (
      .clk        (clk),
      .timerStart (timerStart),
      .load       (dwell_load),
      .load_val   (dwell_val),
      .en         (dwell_en),
      .expired    (dwell_expired)
   );

`ifdef SEQ_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   logic stroke_load, stroke_en, stroke_expired;

   // One watchdog window per stroke: reloaded when each push or return begins.
   assign stroke_en   = (state == PUSH_ACK) || (state == PUSH_WAIT) ||
                        (state == RET_ACK)  || (state == RET_WAIT);
   assign stroke_load = (state_nxt != state) &&
                        ((state_nxt == PUSH_ACK) || (state_nxt == RET_ACK));

   seq_dwell_timer #(.W(TMR_W)) u_stroke_timer (
      .clk        (clk),
      .timerStart (timerStart),
      .load       (stroke_load),
      .load_val   (TIMEOUT_LOAD),
      .en         (stroke_en),
      .expired    (stroke_expired)
   );
`endif

   always_ff @(posedge clk or posedge timerStart) begin
      if (timerStart) begin
         state        <= IDLE;
         servo_bit    <= SERVO_FRONT;
         coins_q      <= '0;
         coin_pulse_q <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         back_d1      <= 1'b0;
         front_d1     <= 1'b0;
      end else begin
         state        <= state_nxt;
         servo_bit    <= servo_nxt;
         coins_q      <= coins_nxt;
         coin_pulse_q <= coin_pulse_nxt;
         done_q       <= done_nxt;
         error_q      <= error_nxt;
         back_d1      <= servo_back_done;
         front_d1     <= servo_front_done;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      servo_nxt      = servo_bit;
      coins_nxt      = coins_q;
      coin_pulse_nxt = 1'b0;
      done_nxt       = 1'b0;
      error_nxt      = error_q;

      case (state)
         IDLE: begin
            if (req_valid) begin
               error_nxt = 1'b0;
               if (req_count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  coins_nxt = req_count;
                  servo_nxt = SERVO_BACK;
                  state_nxt = PUSH_ACK;
               end
            end
         end
         // A done flag that never visibly drops is taken as a pulse too short to sample.
         PUSH_ACK: begin
            if (!back_d1 || dwell_expired) state_nxt = PUSH_WAIT;
         end
         PUSH_WAIT: begin
            if (back_d1) begin
               servo_nxt = SERVO_FRONT;
               state_nxt = RET_ACK;
            end
         end
         RET_ACK: begin
            if (!front_d1 || dwell_expired) state_nxt = RET_WAIT;
         end
         RET_WAIT: begin
            if (front_d1) begin
               coin_pulse_nxt = 1'b1;
               if (coins_q != '0) coins_nxt = coins_q - CNT_W'(1);
               if (coins_nxt == '0) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (dwell_expired) begin
               servo_nxt = SERVO_BACK;
               state_nxt = PUSH_ACK;
            end
         end
         default: state_nxt = IDLE;
      endcase

`ifdef SEQ_TIMEOUT_EN
      // Abort retracts the pusher and leaves coins_left reporting the shortfall.
      if (stroke_en && stroke_expired) begin
         state_nxt      = IDLE;
         servo_nxt      = SERVO_FRONT;
         coins_nxt      = coins_q;
         coin_pulse_nxt = 1'b0;
         done_nxt       = 1'b1;
         error_nxt      = 1'b1;
      end
`endif

      dwell_load = (state_nxt != state);
      dwell_val  = (state_nxt == GAP) ? GAP_LOAD : ACK_LOAD;
      dwell_en   = (state == PUSH_ACK) || (state == RET_ACK) || (state == GAP);
   end

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign servo_ctrl = {31'b0, servo_bit};
   assign coins_left = coins_q;
   assign coin_pulse = coin_pulse_q;
   assign done_pulse = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Scoreboard bench for coin_dispense_sequencer with a behavioural servo model;
// the abort scenario is exercised when SEQ_TIMEOUT_EN is defined.
module tb_coin_dispense_sequencer;

   localparam int CNT_W = 8;
   localparam int GAP   = 10;
   localparam int ACK   = 4;
   localparam int TMO   = 100;

   typedef enum int {M_NORMAL, M_ZERO, M_NEVER} servo_mode_t;

   typedef struct {
      bit coin;
      bit done;
      int coins;
      bit err;
      int rises;
      bit timed_out;
   } exp_t;

   logic             clk = 1'b0;
   logic             timerStart = 1'b1;
   logic             req_valid = 1'b0;
   logic [CNT_W-1:0] req_count = '0;
   logic             req_ready;
   logic [31:0]      servo_ctrl;
   logic             back_done = 1'b1;
   logic             front_done = 1'b1;
   logic             busy;
   logic [CNT_W-1:0] coins_left;
   logic             coin_pulse;
   logic             done_pulse;
   logic             error;

   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   servo_mode_t mode = M_NORMAL;
   int          model_left = 0;

   coin_dispense_sequencer #(
      .CNT_W          (CNT_W),
      .GAP_CYCLES     (GAP),
      .ACK_CYCLES     (ACK),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .timerStart       (timerStart),
      .req_valid        (req_valid),
      .req_count        (req_count),
      .req_ready        (req_ready),
      .servo_ctrl       (servo_ctrl),
      .servo_back_done  (back_done),
      .servo_front_done (front_done),
      .busy             (busy),
      .coins_left       (coins_left),
      .coin_pulse       (coin_pulse),
      .done_pulse       (done_pulse),
      .error            (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Servo model: each ctrl edge drops the matching done flag shortly after and
   // raises it ~20 cycles later; M_ZERO never drops, M_NEVER never raises back_done.
   int   bt = 0, ft = 0;
   logic model_prev = 1'b0;
   always @(negedge clk) begin
      if (timerStart) begin
         bt = 0; ft = 0; model_prev = 1'b0;
         back_done = 1'b1; front_done = 1'b1;
      end else begin
         if (servo_ctrl[0] && !model_prev) bt = 1;
         if (!servo_ctrl[0] && model_prev) ft = 1;
         model_prev = servo_ctrl[0];
         if (bt != 0) begin
            if (bt == 2 && mode != M_ZERO) back_done = 1'b0;
            if (bt == 22 && mode != M_NEVER) begin back_done = 1'b1; bt = 0; end
            else bt++;
         end
         if (ft != 0) begin
            if (ft == 2 && mode != M_ZERO) front_done = 1'b0;
            if (ft == 22) begin front_done = 1'b1; ft = 0; end
            else ft++;
         end
      end
   end

   // Monitor: pops one expected record per cycle carrying coin_pulse/done_pulse.
   int   cyc = 0, rises = 0, rise_cyc = 0, coin_cyc = 0;
   bit   have_coin = 1'b0;
   logic mon_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (timerStart) begin
         rises = 0; have_coin = 1'b0; mon_prev = 1'b0;
      end else begin
         cyc++;
         if (servo_ctrl[0] && !mon_prev) begin
            rises++;
            rise_cyc = cyc;
            if (have_coin) begin
               check("gap_dwell_cycles", 32'(cyc - coin_cyc), 32'(GAP));
               have_coin = 1'b0;
            end
         end
         if (!servo_ctrl[0] && mon_prev && mode == M_ZERO)
            check("ack_expiry_push_width", 32'(cyc - rise_cyc), 32'(ACK + 1));
         mon_prev = servo_ctrl[0];
         if (coin_pulse || done_pulse) begin
            if (sb.size() == 0) begin
               check("unexpected_event", 32'({done_pulse, coin_pulse}), 32'(0));
            end else begin
               e = sb.pop_front();
               check("event_kind", 32'({done_pulse, coin_pulse}), 32'({e.done, e.coin}));
               check("coins_left_at_event", 32'(coins_left), 32'(e.coins));
               if (e.done) begin
                  check("error_at_done", 32'(error), 32'(e.err));
                  check("servo_edges_per_request", 32'(rises), 32'(e.rises));
                  check("servo_front_at_done", servo_ctrl, 32'(0));
                  if (e.timed_out)
                     check("timeout_latency", 32'(cyc - rise_cyc), 32'(TMO));
                  rises = 0;
                  have_coin = 1'b0;
               end else begin
                  have_coin = 1'b1;
                  coin_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic push_expected(input int n);
      exp_t e;
      if (n == 0) begin
         e = '{coin: 1'b0, done: 1'b1, coins: model_left, err: 1'b0, rises: 0, timed_out: 1'b0};
         sb.push_back(e);
      end else if (mode == M_NEVER) begin
         e = '{coin: 1'b0, done: 1'b1, coins: n, err: 1'b1, rises: 1, timed_out: 1'b1};
         sb.push_back(e);
         model_left = n;
      end else begin
         for (int k = n - 1; k >= 0; k--) begin
            e = '{coin: 1'b1, done: (k == 0), coins: k, err: 1'b0, rises: n, timed_out: 1'b0};
            sb.push_back(e);
         end
         model_left = 0;
      end
   endtask

   task automatic send(input int n);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
      check("ready_before_request", 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_count = CNT_W'(n);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      push_expected(n);
      @(negedge clk);
      check("error_cleared_on_accept", 32'(error), 32'(0));
      if (n == 0) begin
         check("zero_req_done_next_cycle", 32'(done_pulse), 32'(1));
         check("zero_req_ready_stays", 32'(req_ready), 32'(1));
         @(negedge clk);
         check("zero_req_done_one_cycle", 32'(done_pulse), 32'(0));
      end else begin
         check("busy_after_accept", 32'(busy), 32'(1));
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || !req_ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(sb.size()), 32'(0));
   endtask

   initial begin
      #12;
      check("reset_req_ready", 32'(req_ready), 32'(1));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_servo_ctrl", servo_ctrl, 32'(0));
      check("reset_coins_left", 32'(coins_left), 32'(0));
      check("reset_coin_pulse", 32'(coin_pulse), 32'(0));
      check("reset_done_pulse", 32'(done_pulse), 32'(0));
      check("reset_error", 32'(error), 32'(0));
      @(negedge clk);
      #2 timerStart = 1'b0;

      mode = M_NORMAL;
      send(3);
      wait_idle("req3_complete", 1000);

      send(0);
      wait_idle("req0_complete", 50);

      // A competing request while busy must be ignored.
      send(3);
      repeat (5) @(negedge clk);
      req_valid = 1'b1;
      req_count = CNT_W'(5);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("ready_low_while_busy", 32'(req_ready), 32'(0));
      end
      req_valid = 1'b0;
      wait_idle("busy_req_ignored", 1000);

      // Asynchronous reset in the middle of the push stroke.
      send(2);
      begin
         int g;
         g = 0;
         while (!servo_ctrl[0] && g < 50) begin @(negedge clk); g++; end
         check("servo_pushed_before_reset", 32'(servo_ctrl[0]), 32'(1));
      end
      repeat (8) @(negedge clk);
      #2 timerStart = 1'b1;
      #1;
      check("async_reset_servo_ctrl", servo_ctrl, 32'(0));
      check("async_reset_busy", 32'(busy), 32'(0));
      check("async_reset_coins_left", 32'(coins_left), 32'(0));
      check("async_reset_req_ready", 32'(req_ready), 32'(1));
      sb.delete();
      model_left = 0;
      @(negedge clk);
      #2 timerStart = 1'b0;

      // Done flags never visibly drop: ACK window expiry must carry the stroke.
      mode = M_ZERO;
      send(2);
      wait_idle("zero_width_flags_complete", 500);

      for (int i = 0; i < 8; i++) begin
         mode = ($urandom_range(0, 1) == 0) ? M_NORMAL : M_ZERO;
         send($urandom_range(0, 5));
         wait_idle("random_request_complete", 2000);
      end

      mode = M_ZERO;
      send(2**CNT_W - 1);
      wait_idle("max_count_complete", 20000);
      check("max_count_coins_left", 32'(coins_left), 32'(0));

`ifdef SEQ_TIMEOUT_EN
      mode = M_NEVER;
      send(2);
      wait_idle("timeout_abort", 500);
      check("timeout_error_sticky", 32'(error), 32'(1));
      check("timeout_coins_held", 32'(coins_left), 32'(2));
      mode = M_NORMAL;
      send(1);
      wait_idle("after_timeout_request", 1000);
      check("error_cleared_next_request", 32'(error), 32'(0));
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
